div_iter: RTL

Multi-cycle iterative divider for the execute stage of the MIPS pipeline, serving DIV/DIVU. It produces the `div_stallE` stall request consumed by the hazard unit: it holds E (and F/D) stalled while the division runs, and delivers {HI=remainder, LO=quotient} to the HI/LO write path in the cycle the stall drops. It uses radix-2 restoring division on magnitudes, with a sign fix-up applied for signed operation.

---
 rtl/div_iter_pkg.sv | 27 ++
 rtl/div_step.sv | 28 ++
 rtl/div_iter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative divider and the HI/LO write path.
package div_iter_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_ITERS = DIV_WIDTH;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // HI/LO packing: HI holds the remainder, LO the quotient.
  typedef struct packed {
    logic [DIV_WIDTH-1:0] hi;
    logic [DIV_WIDTH-1:0] lo;
  } hilo_t;

  function automatic hilo_t pack_hilo(input logic [DIV_WIDTH-1:0] rem,
                                      input logic [DIV_WIDTH-1:0] quo);
    hilo_t r;
    r.hi = rem;
    r.lo = quo;
    return r;
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step on unsigned magnitudes.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] trial;
  logic [WIDTH:0]   rem_sel;
  logic             trial_ok;
  logic             unused_rem_msb;

  // The shifted remainder can exceed WIDTH bits, so the trial carries an extra borrow bit.
  assign rem_sh   = {rem_i, quo_i[WIDTH-1]};
  assign trial    = {1'b0, rem_sh} - {2'b00, divisor_i};
  assign trial_ok = ~trial[WIDTH+1];

  assign rem_sel        = trial_ok ? trial[WIDTH:0] : rem_sh;
  assign rem_o          = rem_sel[WIDTH-1:0];
  assign unused_rem_msb = rem_sel[WIDTH];
  assign quo_o          = {quo_i[WIDTH-2:0], trial_ok};

endmodule

// File: rtl/div_iter.sv
// Multi-cycle iterative DIV/DIVU unit for the execute stage; raises stall while dividing
// and delivers {HI=remainder, LO=quotient} with a one-cycle ready pulse.
module div_iter
  import div_iter_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opb,
  input  logic               cancel,
  output logic               stall,
  output logic [2*WIDTH-1:0] result,
  output logic               ready
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_e         state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic [WIDTH-1:0] opa_abs, opb_abs;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;
  logic [WIDTH-1:0] rem_fix, quo_fix;

  assign opa_abs = (signed_div && opa[WIDTH-1]) ? -opa : opa;
  assign opb_abs = (signed_div && opb[WIDTH-1]) ? -opb : opb;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_i    (rem_q),
    .quo_i    (quo_q),
    .divisor_i(divisor_q),
    .rem_o    (rem_nxt),
    .quo_o    (quo_nxt)
  );

  // Overflow (-2^(W-1) / -1) wraps naturally: magnitude 2^(W-1) with a positive sign.
  assign quo_fix = qneg_q ? -quo_nxt : quo_nxt;
  assign rem_fix = rneg_q ? -rem_nxt : rem_nxt;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    divisor_d = divisor_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    result_d  = result_q;
    unique case (state_q)
      DIV_IDLE: begin
        if (start && !cancel) begin
          if (opb != '0) begin
            rem_d     = '0;
            quo_d     = opa_abs;
            divisor_d = opb_abs;
            qneg_d    = (opa[WIDTH-1] ^ opb[WIDTH-1]) & signed_div;
            rneg_d    = opa[WIDTH-1] & signed_div;
            cnt_d     = '0;
            state_d   = DIV_BUSY;
          end else begin
            result_d = {opa, {WIDTH{1'b1}}};
            state_d  = DIV_DONE;
          end
        end
      end
      DIV_BUSY: begin
        if (cancel || !start) begin
          state_d = DIV_IDLE;
        end else begin
          rem_d = rem_nxt;
          quo_d = quo_nxt;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntW'(WIDTH - 1)) begin
            result_d = {rem_fix, quo_fix};
            state_d  = DIV_DONE;
          end
        end
      end
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      divisor_q <= divisor_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      result_q  <= result_d;
    end
  end

  // Combinational so the hazard unit sees it the cycle the DIV enters E; cancel never stalls.
  assign stall  = start & ~cancel & (state_q != DIV_DONE);
  assign ready  = (state_q == DIV_DONE);
  assign result = result_q;

endmodule
